fetch_queue: RTL and testbench

Parametrised successor to the single-entry fetch stage. It decouples instruction fetch from decode with a DEPTH-entry prefetch queue and issues one instruction-memory read per cycle while credit allows. It presents {next PC, instruction} to decode with a valid/stall handshake. Redirects from decode flush the queue and squash any in-flight read. It sits between instruction memory and the decode/issue stage.

---
 rtl/fetch_queue.sv | 147 ++++++++++++++
 tb/tb_fetch_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// Prefetch queue between instruction memory and decode: one read per cycle while
// credit allows, DEPTH-entry FIFO of {fetch addr + 4, instruction}, redirect flush.
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 7,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         id_stall,
  output logic                         if_id_valid,
  output logic [31:0]                  if_id_nextpc,
  output logic [31:0]                  if_id_instruc,
  input  logic                         id_if_selpcsource,
  input  logic [1:0]                   id_if_selpctype,
  input  logic [31:0]                  id_if_rega,
  input  logic [31:0]                  id_if_pcimd2ext,
  input  logic [31:0]                  id_if_pcindex,
  output logic [$clog2(DEPTH+1)-1:0]   fq_count,
  output logic                         fq_full,
  output logic                         fq_empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      r_pc;
  logic [31:0]      r_pend_pc;
  logic             r_inflight;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_full;
  logic             r_empty;
  logic [31:0]      r_head_pc;
  logic [31:0]      r_head_ins;
  logic [31:0]      r_q_pc  [DEPTH];
  logic [31:0]      r_q_ins [DEPTH];

  logic             w_redirect;
  logic             w_deq;
  logic             w_enq;
  logic             w_issue;
  logic             w_bypass;
  logic [CNT_W:0]   w_occ;
  logic [31:0]      w_target;
  logic [31:0]      w_new_pc;
  logic [31:0]      w_pc_nxt;
  logic [PTR_W-1:0] w_wptr_nxt;
  logic [PTR_W-1:0] w_rptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [31:0]      w_head_pc_nxt;
  logic [31:0]      w_head_ins_nxt;

  // Redirect overrides everything: no pop, no push, no new request.
  assign w_redirect = id_if_selpcsource;
  assign w_deq      = r_valid & ~id_stall & ~w_redirect;
  assign w_enq      = r_inflight & ~w_redirect;
  assign w_occ      = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_deq);
  assign w_issue    = reset & ~w_redirect & (w_occ < (CNT_W+1)'(DEPTH));
  assign w_new_pc   = r_pend_pc + 32'd4;
  // A push into a queue that is empty after this cycle's pop becomes the head directly.
  assign w_bypass   = w_enq & ((r_count - CNT_W'(w_deq)) == '0);

  always_comb begin
    w_target = id_if_pcimd2ext;
    case (id_if_selpctype)
      2'b01:   w_target = id_if_rega;
      2'b10:   w_target = id_if_pcindex;
      2'b11:   w_target = EXC_VECTOR;
      default: w_target = id_if_pcimd2ext;
    endcase
  end

  always_comb begin
    w_pc_nxt       = r_pc;
    w_wptr_nxt     = r_wptr;
    w_rptr_nxt     = r_rptr;
    w_count_nxt    = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    w_head_pc_nxt  = r_head_pc;
    w_head_ins_nxt = r_head_ins;
    if (w_issue) w_pc_nxt = r_pc + 32'd4;
    if (w_enq)   w_wptr_nxt = (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    if (w_deq)   w_rptr_nxt = (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
    if (w_redirect) begin
      w_pc_nxt    = w_target;
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_count_nxt = '0;
    end else if (w_count_nxt != '0) begin
      w_head_pc_nxt  = w_bypass ? w_new_pc   : r_q_pc[w_rptr_nxt];
      w_head_ins_nxt = w_bypass ? imem_rdata : r_q_ins[w_rptr_nxt];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_pend_pc  <= RESET_PC;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_head_pc  <= '0;
      r_head_ins <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_inflight <= w_issue;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_count_nxt;
      r_valid    <= (w_count_nxt != '0);
      r_full     <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      r_head_pc  <= w_head_pc_nxt;
      r_head_ins <= w_head_ins_nxt;
      if (w_issue) r_pend_pc <= r_pc;
    end
  end

  // Queue storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_q_pc[r_wptr]  <= w_new_pc;
      r_q_ins[r_wptr] <= imem_rdata;
    end
  end

  assign imem_req      = w_issue;
  assign imem_addr     = r_pc[ADDR_W+1:2];
  assign if_id_valid   = r_valid;
  assign if_id_nextpc  = r_head_pc;
  assign if_id_instruc = r_head_ins;
  assign fq_count      = r_count;
  assign fq_full       = r_full;
  assign fq_empty      = r_empty;

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
// Directed bench for fetch_queue: streaming, stall/credit, redirects, async reset,
// and DEPTH=2/5 instances starting near the top of the address space.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  stype = 2'b00;
  logic [31:0] rega = '0, imd = '0, idx = '0;
  logic        req, valid, full, empty;
  logic [6:0]  addr;
  logic [31:0] rdata, npc, ins;
  logic [2:0]  cnt;

  logic        rst_x = 1'b0;
  logic        stall_x = 1'b0;
  logic        nosel = 1'b0;
  logic [1:0]  notype = 2'b00;
  logic [31:0] nodata = '0;
  logic        req2, valid2, full2, empty2, req5, valid5, full5, empty5;
  logic [6:0]  addr2, addr5;
  logic [31:0] rdata2, npc2, ins2, rdata5, npc5, ins5;
  logic [1:0]  cnt2;
  logic [2:0]  cnt5;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  // Memory word k holds A000_0000 + k; data returns one cycle after the address.
  always @(posedge clock) begin
    rdata  <= 32'hA000_0000 + 32'(addr);
    rdata2 <= 32'hA000_0000 + 32'(addr2);
    rdata5 <= 32'hA000_0000 + 32'(addr5);
  end

  fetch_queue u_dut (
    .clock(clock), .reset(reset), .imem_req(req), .imem_addr(addr), .imem_rdata(rdata),
    .id_stall(stall), .if_id_valid(valid), .if_id_nextpc(npc), .if_id_instruc(ins),
    .id_if_selpcsource(sel), .id_if_selpctype(stype), .id_if_rega(rega),
    .id_if_pcimd2ext(imd), .id_if_pcindex(idx), .fq_count(cnt), .fq_full(full),
    .fq_empty(empty));

  fetch_queue #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF0)) u_d2 (
    .clock(clock), .reset(rst_x), .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .id_stall(stall_x), .if_id_valid(valid2), .if_id_nextpc(npc2), .if_id_instruc(ins2),
    .id_if_selpcsource(nosel), .id_if_selpctype(notype), .id_if_rega(nodata),
    .id_if_pcimd2ext(nodata), .id_if_pcindex(nodata), .fq_count(cnt2), .fq_full(full2),
    .fq_empty(empty2));

  fetch_queue #(.DEPTH(5), .RESET_PC(32'hFFFF_FFF0)) u_d5 (
    .clock(clock), .reset(rst_x), .imem_req(req5), .imem_addr(addr5), .imem_rdata(rdata5),
    .id_stall(stall_x), .if_id_valid(valid5), .if_id_nextpc(npc5), .if_id_instruc(ins5),
    .id_if_selpcsource(nosel), .id_if_selpctype(notype), .id_if_rega(nodata),
    .id_if_pcimd2ext(nodata), .id_if_pcindex(nodata), .fq_count(cnt5), .fq_full(full5),
    .fq_empty(empty5));

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, expv);
    end
  endtask

  task automatic head(input int c, input logic [31:0] epc, input logic [31:0] eins);
    chk("valid", c, 32'(valid), 32'd1);
    chk("nextpc", c, npc, epc);
    chk("instruc", c, ins, eins);
  endtask

  // Expectations for the DEPTH=2/5 instances: PC starts at FFFF_FFF0 and wraps through 0.
  task automatic xcheck(input string nm, input int c, input int depth, input logic r,
                        input logic [6:0] a, input logic v, input logic [31:0] p,
                        input logic [31:0] i, input logic [31:0] n, input logic f);
    int hidx;
    int ecnt;
    hidx = c - 2;
    if (c < 12) begin
      chk({nm, " req"}, c, 32'(r), 32'd1);
      chk({nm, " addr"}, c, 32'(a), (32'h7C + 32'(c)) & 32'h7F);
      chk({nm, " valid"}, c, 32'(v), 32'(c >= 2));
    end else if (c < 18) begin
      hidx = 10;
      ecnt = (c - 11 < depth) ? c - 11 : depth;
      chk({nm, " count"}, c, n, 32'(ecnt));
      chk({nm, " full"}, c, 32'(f), 32'(ecnt == depth));
      chk({nm, " req"}, c, 32'(r), 32'(c - 10 < depth));
      chk({nm, " valid"}, c, 32'(v), 32'd1);
    end else begin
      hidx = c - 8;
      chk({nm, " valid"}, c, 32'(v), 32'd1);
    end
    if (c >= 2) begin
      chk({nm, " nextpc"}, c, p, 32'hFFFF_FFF4 + 32'(4 * hidx));
      chk({nm, " instruc"}, c, i, 32'hA000_0000 + ((32'h7C + 32'(hidx)) & 32'h7F));
    end
  endtask

  // Status flags must always agree with the occupancy, which may never exceed DEPTH.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      chk("inv count<=DEPTH", -1, 32'(cnt <= 3'd4), 32'd1);
      chk("inv full", -1, 32'(full), 32'(cnt == 3'd4));
      chk("inv empty", -1, 32'(empty), 32'(cnt == 3'd0));
    end
  end

  initial begin
    repeat (2) @(negedge clock);
    #1;
    chk("rst valid", -1, 32'(valid), 32'd0);
    chk("rst nextpc", -1, npc, 32'd0);
    chk("rst instruc", -1, ins, 32'd0);
    chk("rst req", -1, 32'(req), 32'd0);
    chk("rst count", -1, 32'(cnt), 32'd0);
    chk("rst empty", -1, 32'(empty), 32'd1);

    // Free-running stream from RESET_PC
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("req", c, 32'(req), 32'd1);
      chk("addr", c, 32'(addr), 32'(c));
      chk("count", c, 32'(cnt), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) head(c, 32'(4 * (c - 1)), 32'hA000_0000 + 32'(c - 2));
      else chk("valid", c, 32'(valid), 32'd0);
    end

    // Stall for 10 cycles: queue fills, credit stops requests, head held
    for (int c = 6; c < 16; c++) begin
      @(negedge clock);
      stall = 1'b1;
      #1;
      head(c, 32'h14, 32'hA000_0004);
      chk("count", c, 32'(cnt), (c < 9) ? 32'(c - 5) : 32'd4);
      chk("full", c, 32'(full), 32'(c >= 9));
      chk("req", c, 32'(req), 32'(c < 8));
    end

    // Release: drain in order while refilling
    for (int c = 16; c < 24; c++) begin
      @(negedge clock);
      stall = 1'b0;
      #1;
      head(c, 32'(4 * (c - 11)), 32'hA000_0000 + 32'(c - 12));
      chk("addr", c, 32'(addr), 32'(c - 8));
      chk("req", c, 32'(req), 32'd1);
      chk("count", c, 32'(cnt), (c == 16) ? 32'd4 : 32'd3);
    end

    // Branch redirect with 3 entries queued and a read in flight
    @(negedge clock); sel = 1'b1; stype = 2'b00; imd = 32'h100; #1;
    chk("redir req", 24, 32'(req), 32'd0);
    chk("redir count", 24, 32'(cnt), 32'd3);
    head(24, 32'h34, 32'hA000_000C);
    @(negedge clock); sel = 1'b0; #1;
    chk("post valid", 25, 32'(valid), 32'd0);
    chk("post count", 25, 32'(cnt), 32'd0);
    chk("post empty", 25, 32'(empty), 32'd1);
    chk("post addr", 25, 32'(addr), 32'd64);
    chk("post req", 25, 32'(req), 32'd1);
    @(negedge clock); #1;
    chk("post valid", 26, 32'(valid), 32'd0);
    chk("post addr", 26, 32'(addr), 32'd65);
    @(negedge clock); #1;
    head(27, 32'h104, 32'hA000_0040);
    @(negedge clock); #1;
    head(28, 32'h108, 32'hA000_0041);

    // Exception redirect while stalled
    @(negedge clock); stall = 1'b1; sel = 1'b1; stype = 2'b11;
    rega = 32'h500; idx = 32'h600; imd = 32'h700; #1;
    chk("exc req", 29, 32'(req), 32'd0);
    @(negedge clock); sel = 1'b0; #1;
    chk("exc valid", 30, 32'(valid), 32'd0);
    chk("exc addr", 30, 32'(addr), 32'd16);
    @(negedge clock); #1;
    chk("exc valid", 31, 32'(valid), 32'd0);
    chk("exc addr", 31, 32'(addr), 32'd17);
    @(negedge clock); #1;
    head(32, 32'h44, 32'hA000_0010);
    chk("exc count", 32, 32'(cnt), 32'd1);
    @(negedge clock); #1;
    head(33, 32'h44, 32'hA000_0010);
    chk("exc count", 33, 32'(cnt), 32'd2);

    // Back-to-back redirects: register target, then jump target wins
    @(negedge clock); stall = 1'b0; sel = 1'b1; stype = 2'b01; rega = 32'h200; #1;
    chk("b2b req", 34, 32'(req), 32'd0);
    @(negedge clock); stype = 2'b10; idx = 32'h180; #1;
    chk("b2b req", 35, 32'(req), 32'd0);
    chk("b2b valid", 35, 32'(valid), 32'd0);
    chk("b2b count", 35, 32'(cnt), 32'd0);
    @(negedge clock); sel = 1'b0; #1;
    chk("b2b addr", 36, 32'(addr), 32'd96);
    chk("b2b valid", 36, 32'(valid), 32'd0);
    @(negedge clock); #1;
    chk("b2b addr", 37, 32'(addr), 32'd97);
    chk("b2b valid", 37, 32'(valid), 32'd0);
    @(negedge clock); stall = 1'b1; #1;
    head(38, 32'h184, 32'hA000_0060);
    chk("b2b req", 38, 32'(req), 32'd1);

    // Asynchronous reset with 2 entries queued and a read in flight
    @(negedge clock); #1;
    chk("pre-rst count", 39, 32'(cnt), 32'd2);
    chk("pre-rst addr", 39, 32'(addr), 32'd99);
    #2 reset = 1'b0;
    #1;
    chk("arst valid", 39, 32'(valid), 32'd0);
    chk("arst nextpc", 39, npc, 32'd0);
    chk("arst instruc", 39, ins, 32'd0);
    chk("arst count", 39, 32'(cnt), 32'd0);
    chk("arst empty", 39, 32'(empty), 32'd1);
    chk("arst req", 39, 32'(req), 32'd0);
    @(negedge clock); reset = 1'b1; stall = 1'b0; #1;
    chk("rel req", 40, 32'(req), 32'd1);
    chk("rel addr", 40, 32'(addr), 32'd0);
    chk("rel valid", 40, 32'(valid), 32'd0);
    @(negedge clock); #1;
    chk("rel addr", 41, 32'(addr), 32'd1);
    chk("rel valid", 41, 32'(valid), 32'd0);
    @(negedge clock); #1;
    head(42, 32'h4, 32'hA000_0000);

    // DEPTH=2 and DEPTH=5: PC wrap, pointer wrap, saturation and drain
    chk("d2 rst count", -1, 32'(cnt2), 32'd0);
    chk("d5 rst empty", -1, 32'(empty5), 32'd1);
    chk("d5 rst req", -1, 32'(req5), 32'd0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      rst_x = 1'b1;
      stall_x = (c >= 12 && c < 18);
      #1;
      xcheck("d2", c, 2, req2, addr2, valid2, npc2, ins2, 32'(cnt2), full2);
      xcheck("d5", c, 5, req5, addr5, valid5, npc5, ins5, 32'(cnt5), full5);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
